// File: rtl/dmem_seq_pkg.sv
// Shared encodings for the byte-serial data memory sequencer.
// Holds the access-type codes, the FSM state codes and the beat-count helper.
package dmem_seq_pkg;

    localparam logic [2:0] NUM_W  = 3'b000;
    localparam logic [2:0] NUM_HS = 3'b001;
    localparam logic [2:0] NUM_HU = 3'b010;
    localparam logic [2:0] NUM_BS = 3'b011;
    localparam logic [2:0] NUM_BU = 3'b100;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BEAT  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] FIN   = 2'd3;

    // Number of byte beats for an access type; 0 marks an invalid code.
    function automatic logic [2:0] beats_of(input logic [2:0] num);
        logic [2:0] n;
        case (num)
            NUM_W:          n = 3'd4;
            NUM_HS, NUM_HU: n = 3'd2;
            NUM_BS, NUM_BU: n = 3'd1;
            default:        n = 3'd0;
        endcase
        return n;
    endfunction

    function automatic logic num_valid(input logic [2:0] num);
        return beats_of(num) != 3'd0;
    endfunction

endpackage

// File: rtl/dmem_load_assemble.sv
// Load-data assembly: registers each returned RAM byte into its lane one cycle
// after its read beat and applies sign/zero extension with the final byte.
module dmem_load_assemble
    import dmem_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        beat_valid,
    input  logic [1:0]  beat_idx,
    input  logic [2:0]  num,
    input  logic [7:0]  mem_rdata,
    output logic [31:0] rdata
);

    logic        cap_valid;
    logic [1:0]  cap_idx;
    logic [31:0] data_q;
    logic [31:0] data_d;

    // RAM data lags the read beat by one cycle, so the beat tag is delayed to match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_valid <= 1'b0;
            cap_idx   <= 2'd0;
        end else begin
            cap_valid <= beat_valid;
            cap_idx   <= beat_idx;
        end
    end

    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = '0;
        end else if (cap_valid) begin
            data_d[8*cap_idx +: 8] = mem_rdata;
            // Upper bits are already zero from the accept-time clear; only signed types need filling.
            case (num)
                NUM_HS:  if (cap_idx == 2'd1) data_d[31:16] = {16{mem_rdata[7]}};
                NUM_BS:  if (cap_idx == 2'd0) data_d[31:8]  = {24{mem_rdata[7]}};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= '0;
        else        data_q <= data_d;
    end

    assign rdata = data_q;

endmodule

// File: rtl/dmem_byte_seq.sv
// Byte-serial load/store sequencer between the CPU LSU and a byte-wide sync RAM.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned word/half requests with err.
module dmem_byte_seq
    import dmem_seq_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        num,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    logic [1:0]        state;
    logic [1:0]        state_d;
    logic [1:0]        cnt;
    logic              we_q;
    logic [2:0]        num_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic              accept;
    logic              reject;
    logic              misalign;
    logic              last;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^addr[31:ADDR_W];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = ((num == NUM_W) && (addr[1:0] != 2'b00)) ||
                      (((num == NUM_HS) || (num == NUM_HU)) && addr[0]);
`else
    assign misalign = 1'b0;
`endif

    // FIN keeps busy low so a request in the done cycle is taken without a gap.
    assign busy   = (state == BEAT) || (state == DRAIN);
    assign accept = req && !busy;
    assign reject = !num_valid(num) || misalign;
    assign last   = ({1'b0, cnt} == (beats_of(num_q) - 3'd1));

    always_comb begin
        state_d = state;
        case (state)
            IDLE, FIN: begin
                if (accept) state_d = reject ? FIN : BEAT;
                else        state_d = IDLE;
            end
            BEAT:    if (last) state_d = we_q ? FIN : DRAIN;
            DRAIN:   state_d = FIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            we_q    <= 1'b0;
            num_q   <= NUM_W;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_d;
            if (accept) begin
                cnt     <= 2'd0;
                we_q    <= we;
                num_q   <= num;
                addr_q  <= addr[ADDR_W-1:0];
                wdata_q <= wdata;
                err_q   <= reject;
            end else if (state == BEAT) begin
                cnt <= cnt + 2'd1;
            end
        end
    end

    assign mem_en    = (state == BEAT);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = addr_q + ADDR_W'(cnt);
    assign mem_wdata = wdata_q[8*cnt +: 8];
    assign done      = (state == FIN);
    assign err       = done && err_q;

    dmem_load_assemble u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (accept),
        .beat_valid (mem_en && !we_q),
        .beat_idx   (cnt),
        .num        (num_q),
        .mem_rdata  (mem_rdata),
        .rdata      (rdata)
    );

endmodule

// File: tb/tb_dmem_byte_seq.sv
// Scoreboard bench for dmem_byte_seq: the driver queues expected beats and
// completions, an independent negedge monitor pops and compares them.
module tb_dmem_byte_seq;

    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req;
    logic              we;
    logic [2:0]        num;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              busy;
    logic              done;
    logic              err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    dmem_byte_seq #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .num       (num),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned       cyc;
        logic [ADDR_W-1:0] a;
        logic              w;
        logic [7:0]        d;
    } beat_t;

    typedef struct {
        int unsigned cyc;
        logic [31:0] r;
        logic        e;
        logic        chk_r;
    } resp_t;

    beat_t bq[$];
    resp_t rq[$];
    int n_checks = 0;
    int n_pass   = 0;
    int unsigned last_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    beat_t mb;
    resp_t mr;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (mem_we && !mem_en) check("mem_we_without_en", {31'd0, mem_we}, 32'd0);
            if (err && !done)      check("err_without_done", {31'd0, err}, 32'd0);
            if (mem_en) begin
                if (bq.size() == 0) begin
                    check("unexpected_beat", {21'd0, mem_addr}, 32'hFFFF_FFFF);
                end else begin
                    mb = bq.pop_front();
                    check("beat_cycle", cyc, mb.cyc);
                    check("beat_addr", {21'd0, mem_addr}, {21'd0, mb.a});
                    check("beat_we", {31'd0, mem_we}, {31'd0, mb.w});
                    if (mb.w) check("beat_wdata", {24'd0, mem_wdata}, {24'd0, mb.d});
                    check("beat_busy", {31'd0, busy}, 32'd1);
                end
            end
            if (done) begin
                if (rq.size() == 0) begin
                    check("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    mr = rq.pop_front();
                    check("done_cycle", cyc, mr.cyc);
                    check("done_busy", {31'd0, busy}, 32'd0);
                    check("done_err", {31'd0, err}, {31'd0, mr.e});
                    if (mr.chk_r) check("rdata", rdata, mr.r);
                end
            end
        end
    end

    // Drives one request (holding req until accepted) and queues its expected beats/completion.
    task automatic issue(input logic w, input logic [2:0] n, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_r, input logic chk_r);
        int unsigned nb;
        int unsigned lat;
        int unsigned e;
        int unsigned k;
        logic bad;
        beat_t b;
        resp_t r;
        @(negedge clk);
        we = w; num = n; addr = a; wdata = d; req = 1'b1;
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            check("accept_timeout", {31'd0, busy}, 32'd0);
            req = 1'b0;
            return;
        end
        e = cyc + 1;
        last_e = e;
        case (n)
            3'b000:         nb = 4;
            3'b001, 3'b010: nb = 2;
            3'b011, 3'b100: nb = 1;
            default:        nb = 0;
        endcase
        bad = (nb == 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (n == 3'b000 && a[1:0] != 2'b00) bad = 1'b1;
        if ((n == 3'b001 || n == 3'b010) && a[0]) bad = 1'b1;
`endif
        if (bad)    lat = 1;
        else if (w) lat = nb + 1;
        else        lat = nb + 2;
        r.cyc = e + lat - 1;
        r.r = bad ? 32'd0 : exp_r;
        r.e = bad;
        r.chk_r = bad | chk_r;
        rq.push_back(r);
        if (!bad) begin
            for (int unsigned i = 0; i < nb; i++) begin
                b.cyc = e + i;
                b.a = a[ADDR_W-1:0] + ADDR_W'(i);
                b.w = w;
                b.d = d[8*i +: 8];
                bq.push_back(b);
            end
        end
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned k;
        k = 0;
        while ((bq.size() != 0 || rq.size() != 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (bq.size() != 0 || rq.size() != 0) begin
            check("drain_timeout", bq.size() + rq.size(), 32'd0);
            bq.delete();
            rq.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not terminate");
        $fatal(1);
    end

    initial begin
        int unsigned k;
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 8'h00;
        ram[11'h020] = 8'h34;
        ram[11'h021] = 8'h82;
        ram[11'h030] = 8'h80;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; num = 3'b000; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {21'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // store word, then signed/unsigned half and byte loads
        issue(1'b1, 3'b000, 32'h010, 32'hA1B2C3D4, 32'h0, 1'b0);
        wait_idle();
        check("ram_010", {24'd0, ram[11'h010]}, 32'hD4);
        check("ram_013", {24'd0, ram[11'h013]}, 32'hA1);
        issue(1'b0, 3'b001, 32'h020, 32'h0, 32'hFFFF8234, 1'b1);
        issue(1'b0, 3'b010, 32'h020, 32'h0, 32'h00008234, 1'b1);
        issue(1'b0, 3'b011, 32'h030, 32'h0, 32'hFFFFFF80, 1'b1);
        issue(1'b0, 3'b100, 32'h030, 32'h0, 32'h00000080, 1'b1);
        issue(1'b0, 3'b000, 32'h010, 32'h0, 32'hA1B2C3D4, 1'b1);
        wait_idle();

        // back-to-back: second request held high through the first
        issue(1'b1, 3'b001, 32'h040, 32'h0000BEEF, 32'h0, 1'b0);
        issue(1'b0, 3'b010, 32'h040, 32'h0, 32'h0000BEEF, 1'b1);
        wait_idle();

        // a req pulse while busy is dropped
        issue(1'b0, 3'b000, 32'h010, 32'h0, 32'hA1B2C3D4, 1'b1);
        @(negedge clk);
        we = 1'b1; num = 3'b000; addr = 32'h200; wdata = 32'hDEADBEEF; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_idle();
        check("ignored_req_ram", {24'd0, ram[11'h200]}, 32'h00);

        // invalid access types
        issue(1'b0, 3'b110, 32'h010, 32'h0, 32'h0, 1'b1);
        issue(1'b1, 3'b101, 32'h010, 32'hFFFFFFFF, 32'h0, 1'b1);
        issue(1'b0, 3'b111, 32'h010, 32'h0, 32'h0, 1'b1);
        wait_idle();
        check("invalid_no_write", {24'd0, ram[11'h010]}, 32'hD4);

        // misaligned accesses (rejected only with the trap build)
        issue(1'b1, 3'b000, 32'h002, 32'hCAFEF00D, 32'h0, 1'b0);
        issue(1'b0, 3'b000, 32'h002, 32'h0, 32'hCAFEF00D, 1'b1);
        issue(1'b0, 3'b001, 32'h021, 32'h0, 32'h00000082, 1'b1);
        wait_idle();

        // address wrap at the top of RAM; upper address bits ignored
        issue(1'b1, 3'b000, 32'h7FF, 32'h11223344, 32'h0, 1'b0);
        issue(1'b0, 3'b000, 32'hFFFFF7FF, 32'h0, 32'h11223344, 1'b1);
        wait_idle();
        check("wrap_ram_7ff", {24'd0, ram[11'h7FF]}, 32'h44);
        check("wrap_ram_002", {24'd0, ram[11'h002]}, 32'h11);

        // reset during beat 2 of a word store
        issue(1'b1, 3'b000, 32'h100, 32'h55667788, 32'h0, 1'b0);
        k = 0;
        while (cyc != last_e + 2 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("reset_point_reached", cyc, last_e + 2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_mem_en", {31'd0, mem_en}, 32'd0);
        check("midrst_mem_we", {31'd0, mem_we}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        bq.delete();
        rq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_ram_100", {24'd0, ram[11'h100]}, 32'h88);
        check("midrst_ram_101", {24'd0, ram[11'h101]}, 32'h77);
        check("midrst_ram_102", {24'd0, ram[11'h102]}, 32'h00);
        check("midrst_ram_103", {24'd0, ram[11'h103]}, 32'h00);
        issue(1'b0, 3'b100, 32'h101, 32'h0, 32'h00000077, 1'b1);
        issue(1'b0, 3'b000, 32'h100, 32'h0, 32'h00007788, 1'b1);
        wait_idle();

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_byte_seq.md
Name: dmem_byte_seq

Overview:
- Controller between the CPU load/store stage and a byte-wide synchronous data RAM.
- Accepts one 32-bit load/store request, then sequences 1, 2 or 4 byte beats on the RAM port, little-endian.
- For loads, assembles the returned bytes and sign- or zero-extends them to 32 bits.
- Holds `busy` high so the pipeline stalls until `done`.

Parameters:
- ADDR_W, 11, RAM byte-address width; `mem_addr` wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  1  request strobe; sampled only when busy=0
- we  in  1  1=store, 0=load
- num  in  3  access type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned
- addr  in  32  byte address of the access; low ADDR_W bits used
- wdata  in  32  store data; byte i is wdata[8i+7:8i]
- rdata  out  32  load result, valid while done=1, held until next accept
- busy  out  1  request in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done for a rejected request
- mem_en  out  1  RAM beat enable
- mem_we  out  1  RAM write enable, qualified by mem_en
- mem_addr  out  ADDR_W  RAM byte address
- mem_wdata  out  8  RAM write byte
- mem_rdata  in  8  RAM read byte, valid the cycle after the read beat

Behaviour:
- Reset (async, rst_n=0), forced immediately:
  - busy=0, done=0, err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0.
  - State=IDLE.
  - Any in-flight access is abandoned; no further beats are issued.
- Beat count N: 4 for num=000, 2 for 001/010, 1 for 011/100.
- num=101..111 is invalid:
  - Accepted, but no RAM beat is issued.
  - Next cycle: done=1, err=1, rdata=0, busy=0.
- Accept: at the edge where req=1 and busy=0.
  - Latches we, num, addr, wdata.
  - busy=1 from the next cycle.
- States and transitions:
  - IDLE -> BEAT: on valid accept.
  - BEAT: beat counter i=0..N-1, one per cycle.
    - mem_en=1, mem_addr=addr+i (ADDR_W wrap), mem_we=we, mem_wdata=wdata byte i.
  - BEAT -> DRAIN: loads only, after beat N-1. Captures the final byte returned.
  - BEAT -> FIN: stores, after beat N-1.
  - DRAIN -> FIN.
  - FIN: done=1, busy=0, then IDLE.
- Latency, with accept at edge T:
  - Beats occupy cycles T+1..T+N.
  - Store: done in cycle T+N+1.
  - Load: done in cycle T+N+2.
  - Invalid num: done in cycle T+1.
- Load capture: byte from beat i is registered into rdata[8i+7:8i] in the cycle after that beat. The extension below is applied when done rises:
  - 001: rdata[31:16] = {16{byte1[7]}}
  - 010: rdata[31:16] = 0
  - 011: rdata[31:8] = {24{byte0[7]}}
  - 100: rdata[31:8] = 0
- Back-to-back: busy=0 in the FIN cycle, so a req in the done cycle is accepted. Its first beat follows immediately, giving no idle gap.
- req while busy=1: ignored, not queued.
- mem_en=0 outside BEAT. mem_we is never 1 when mem_en=0.
- Address wrap: addr=2^ADDR_W-1 with num=000 gives beats at 0x7FF, 0x000, 0x001, 0x002 (ADDR_W=11).

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN
- Defined:
  - Word requests with addr[1:0]≠0 are rejected.
  - Half requests with addr[0]≠0 are rejected.
  - Rejection follows the invalid-num path: no beats, done+err in T+1, rdata=0.
- Undefined: misaligned accesses proceed byte-serially as normal, and err is asserted only for invalid num.

Decomposition:
- Package dmem_seq_pkg holds:
  - num encoding constants (NUM_W, NUM_HS, NUM_HU, NUM_BS, NUM_BU).
  - State encoding (IDLE, BEAT, DRAIN, FIN).
  - Function beats_of(num) returning N.
- One sub-module, dmem_load_assemble: byte capture register plus sign/zero extension, driven by beat index, valid and num.
- Sequencing FSM and beat counter stay in the top module.

Test Plan:
- Store word: addr=0x010, wdata=0xA1B2C3D4 -> beats T+1..T+4 write 0xD4,0xC3,0xB2,0xA1 to 0x010..0x013; done in T+5; busy high T+1..T+4.
- Load half signed: RAM[0x020]=0x34, RAM[0x021]=0x82, num=001 -> rdata=0xFFFF8234 with done in T+4. Same access with num=010 -> rdata=0x00008234.
- Load byte signed: num=011, byte 0x80 -> 0xFFFFFF80. num=100 -> 0x00000080, with done in T+3.
- Back-to-back: second req held high through the first access -> accepted in the done cycle; first beat of the second access follows with no idle cycle. A req pulsed mid-access is ignored.
- Reset mid-operation: rst_n low during beat 2 of a word store -> mem_en and busy drop immediately, and no further writes occur. After rst_n rises, a new load completes normally.
- Error cases:
  - num=110 -> done=err=1 at T+1, no mem_en.
  - With DMEM_MISALIGN_TRAP_EN, word at addr=0x002 -> err. Without it, beats at 0x002..0x005.
  - Wrap case at addr=0x7FF checked.
